// File: rtl/load_wb_unit.sv
// rtl/load_wb_unit.sv - load completion and register write-back unit
// Issues one word-aligned memory read per load, extracts and extends the addressed data, writes it back once.
module load_wb_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  input  logic [4:0]  ld_rd,
  output logic        ld_err,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_req_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic        mem_rdata_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  waddr_q, waddr_d;

  logic        bad_f3;
  logic        misalign;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_v;

  assign bad_f3   = (ld_funct3 == 3'b011) || (ld_funct3 == 3'b110) || (ld_funct3 == 3'b111);
  // funct3[1:0]==01 covers both LH and LHU
  assign misalign = ((ld_funct3[1:0] == 2'b01) && ld_addr[0]) ||
                    ((ld_funct3 == 3'b010) && (ld_addr[1:0] != 2'b00));

  always_comb begin
    byte_v = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    byte_v = mem_rdata[7:0];
      2'd1:    byte_v = mem_rdata[15:8];
      2'd2:    byte_v = mem_rdata[23:16];
      default: byte_v = mem_rdata[31:24];
    endcase
    half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ext_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext_v = {{16{half_v[15]}}, half_v};
      3'b100:  ext_v = {24'h0, byte_v};
      3'b101:  ext_v = {16'h0, half_v};
      default: ext_v = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    err_d    = 1'b0;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          addr_d   = ld_addr;
          funct3_d = ld_funct3;
          rd_d     = ld_rd;
          if (bad_f3 || misalign) begin
            err_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (mem_rdata_valid) begin
          wdata_d = ext_v;
          waddr_d = rd_q;
          state_d = WB;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0;
      funct3_q <= 3'h0;
      rd_q     <= 5'h0;
      err_q    <= 1'b0;
      wdata_q  <= 32'h0;
      waddr_q  <= 5'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
    end
  end

  assign ld_ready        = (state_q == IDLE);
  assign ld_err          = err_q;
  assign mem_addr        = {addr_q[31:2], 2'b00};
  assign mem_read        = (state_q == REQ);
  assign mem_rdata_ready = (state_q == WAIT);
  assign rf_wen          = (state_q == WB) && (rd_q != 5'd0);
  assign rf_waddr        = waddr_q;
  assign rf_wdata        = wdata_q;

endmodule

// File: tb/tb_load_wb_unit.sv
// tb/tb_load_wb_unit.sv - scoreboard bench for load_wb_unit
// Driver pushes expected write-backs; a monitor pops and compares on every rf_wen.
module tb_load_wb_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [4:0]  ld_rd;
  logic        ld_err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_req_ready;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_rdata_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  load_wb_unit dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_funct3(ld_funct3), .ld_rd(ld_rd), .ld_err(ld_err),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata_ready(mem_rdata_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  total_cnt = 0;
  int  pass_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3,
                                            input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (16 * addr[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32768) ? h - 32'd65536 : h;
      3'b010:  return word;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [31:0] addr, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return addr[0] == 1'b0;
      3'b010:         return addr[1:0] == 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rf_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("rf_wen_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rf_waddr", 32'(rf_waddr), 32'(mon_e.waddr));
          chk("rf_wdata", rf_wdata, mon_e.wdata);
        end
      end
    end
  end

  // Entered and left at 1ns after a rising edge with the unit in IDLE.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] word, input int rs, input int ds);
    wb_t e;
    chk("ld_ready_idle", 32'(ld_ready), 32'd1);
    ld_valid  = 1'b1;
    ld_addr   = addr;
    ld_funct3 = f3;
    ld_rd     = rd;
    @(posedge clk); #1;
    ld_valid  = 1'b0;
    ld_addr   = $urandom;
    ld_funct3 = 3'($urandom_range(0, 7));
    ld_rd     = 5'($urandom_range(0, 31));
    if (!is_legal(addr, f3)) begin
      chk("ld_err_pulse", 32'(ld_err), 32'd1);
      chk("err_ready", 32'(ld_ready), 32'd1);
      chk("err_no_read", 32'(mem_read), 32'd0);
      @(posedge clk); #1;
      chk("ld_err_once", 32'(ld_err), 32'd0);
      chk("err_no_read2", 32'(mem_read), 32'd0);
      return;
    end
    if (rd != 5'd0) begin
      e.waddr = rd;
      e.wdata = ref_load(addr, f3, word);
      exp_q.push_back(e);
    end
    for (int i = 0; i <= rs; i++) begin
      mem_req_ready   = (i == rs);
      mem_rdata_valid = 1'($urandom_range(0, 1));
      mem_rdata       = $urandom;
      #1;
      chk("mem_read", 32'(mem_read), 32'd1);
      chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      @(posedge clk); #1;
    end
    mem_req_ready = 1'($urandom_range(0, 1));
    for (int j = 0; j <= ds; j++) begin
      mem_rdata_valid = (j == ds);
      mem_rdata       = (j == ds) ? word : $urandom;
      #1;
      chk("rdata_ready", 32'(mem_rdata_ready), 32'd1);
      chk("wait_no_read", 32'(mem_read), 32'd0);
      @(posedge clk); #1;
    end
    mem_rdata_valid = 1'($urandom_range(0, 1));
    mem_rdata       = $urandom;
    mem_req_ready   = 1'b0;
    #1;
    chk("rf_wen_timing", 32'(rf_wen), 32'(rd != 5'd0));
    @(posedge clk); #1;
    mem_rdata_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
    chk({tag, "_ld_err"}, 32'(ld_err), 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_rdata_ready"}, 32'(mem_rdata_ready), 32'd0);
    chk({tag, "_rf_wen"}, 32'(rf_wen), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'd0);
    chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, w;
    logic [2:0]  f;
    logic [4:0]  r;
    rst = 1'b0;
    ld_valid = 1'b0; ld_addr = 32'h0; ld_funct3 = 3'h0; ld_rd = 5'h0;
    mem_req_ready = 1'b0; mem_rdata = 32'h0; mem_rdata_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    do_load(32'h1000_0004, 3'b010, 5'd5, 32'hDEADBEEF, 0, 0);
    do_load(32'h0000_0103, 3'b000, 5'd3, 32'h80FF_0000, 0, 0);
    do_load(32'h0000_0103, 3'b100, 5'd4, 32'h80FF_0000, 0, 0);
    do_load(32'h0000_0202, 3'b001, 5'd6, 32'h8001_1234, 0, 0);
    do_load(32'h0000_0202, 3'b101, 5'd7, 32'h8001_1234, 0, 0);
    do_load(32'h0000_0040, 3'b010, 5'd9, 32'h1234_5678, 3, 2);
    do_load(32'h0000_0302, 3'b010, 5'd10, 32'h0, 0, 0);
    do_load(32'h0000_0300, 3'b011, 5'd11, 32'h0, 0, 0);
    do_load(32'h0000_0500, 3'b010, 5'd0, 32'hCAFE_F00D, 0, 0);

    // Reset while WAIT has valid data presented: the response must be dropped.
    ld_valid = 1'b1; ld_addr = 32'h2000_0008; ld_funct3 = 3'b010; ld_rd = 5'd7;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_rdata_valid = 1'b1;
    mem_rdata = $urandom;
    #1 rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); #1;
    rst = 1'b1;
    mem_rdata_valid = 1'b0;
    #1;
    chk("postreset_rf_wen", 32'(rf_wen), 32'd0);
    chk("postreset_ready", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;

    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      f = 3'($urandom_range(0, 7));
      r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      w = $urandom;
      do_load(a, f, r, w, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
